// File: rtl/ldr_pkg.sv
// Shared definitions for the LDR Avalon-MM driver: slave register map,
// driver state encoding and default predictor order.
package ldr_pkg;

    localparam int LDR_ORDER = 10;

    localparam logic [15:0] LDR_ADDR_RESET  = 16'h0000;
    localparam logic [15:0] LDR_ADDR_START  = 16'h0001;
    localparam logic [15:0] LDR_ADDR_DONE   = 16'h0002;
    localparam logic [15:0] LDR_ADDR_R_BASE = 16'h0003;
    localparam logic [15:0] LDR_ADDR_A_BASE = 16'h000E;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RSTH,
        ST_RSTL,
        ST_LOAD,
        ST_GO,
        ST_POLL,
        ST_PCHK,
        ST_GAP,
        ST_STOP,
        ST_RDA,
        ST_OUT,
        ST_ABORT
    } drv_state_e;

endpackage

// File: rtl/ldr_poll_timer.sv
// Poll pacing for the LDR driver: counts idle cycles between done polls and
// the number of polls issued since the run started (saturating, never wraps).
module ldr_poll_timer #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    output logic gap_done,
    output logic expired
);

    localparam int PW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_MAX  = GW'(POLL_GAP);

    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    // The gap counter restarts on every poll and free-runs up to POLL_GAP,
    // so the cycle after the poll check is gap cycle 1.
    always_comb begin
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        if (start) begin
            poll_cnt_d = '0;
            gap_cnt_d  = '0;
        end else if (tick) begin
            if (poll_cnt_q != POLL_MAX) begin
                poll_cnt_d = poll_cnt_q + PW'(1);
            end
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign gap_done = (gap_cnt_q == GAP_MAX);
    assign expired  = (poll_cnt_q == POLL_MAX);

endmodule

// File: rtl/ldr_avm_driver.sv
// Avalon-MM master that sequences one Levinson-Durbin solve on the LDR slave:
// load R, start, poll done, read back A and hand the coefficients downstream.
module ldr_avm_driver
    import ldr_pkg::*;
#(
    parameter int ORDER    = LDR_ORDER,
    parameter int DW       = 16,
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [(ORDER+1)*DW-1:0] r_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(ORDER+1)*DW-1:0] a_vec,
    output logic                  timeout,
    output logic [15:0]           avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DW-1:0]         avm_writedata,
    input  logic [DW-1:0]         avm_readdata
);

    localparam int N  = ORDER + 1;
    localparam int IW = $clog2(N + 1);

    drv_state_e      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N*DW-1:0] r_q, r_d;
    logic [N*DW-1:0] a_q, a_d;
    logic            timeout_q, timeout_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            avm_read_q, avm_read_d;
    logic            avm_write_q, avm_write_d;
    logic [15:0]     avm_address_q, avm_address_d;
    logic [DW-1:0]   avm_writedata_q, avm_writedata_d;

    logic timer_start;
    logic poll_tick;
    logic gap_done;
    logic expired;

    assign poll_tick = (state_q == ST_POLL);

    ldr_poll_timer #(
        .POLL_GAP(POLL_GAP),
        .TIMEOUT (TIMEOUT)
    ) u_poll_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start),
        .tick    (poll_tick),
        .gap_done(gap_done),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        r_d         = r_q;
        a_d         = a_q;
        timeout_d   = timeout_q;
        timer_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_ready_q && in_valid) begin
                    r_d         = r_vec;
                    timeout_d   = 1'b0;
                    timer_start = 1'b1;
                    state_d     = ST_RSTH;
                end
            end
            ST_RSTH: state_d = ST_RSTL;
            ST_RSTL: begin
                idx_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (idx_q == IW'(ORDER)) begin
                    idx_d   = '0;
                    state_d = ST_GO;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_GO:   state_d = ST_POLL;
            ST_POLL: state_d = ST_PCHK;
            ST_PCHK: begin
                idx_d = '0;
                if (avm_readdata[0]) begin
                    state_d = ST_STOP;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_POLL;
                end
            end
            ST_STOP: begin
                idx_d   = '0;
                state_d = ST_RDA;
            end
            // Reads are issued while idx < N; readdata for read k lands while idx = k+1.
            ST_RDA: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IW'(i + 1)) begin
                        a_d[i*DW +: DW] = avm_readdata;
                    end
                end
                if (idx_q == IW'(N)) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (idx_q == '0) begin
                    idx_d = IW'(1);
                end else begin
                    idx_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs are registered from the state being entered,
    // so each state cycle carries exactly its own transfer.
    always_comb begin
        avm_read_d      = 1'b0;
        avm_write_d     = 1'b0;
        avm_address_d   = '0;
        avm_writedata_d = '0;
        in_ready_d      = (state_q == ST_IDLE) && (state_d == ST_IDLE);
        out_valid_d     = (state_d == ST_OUT);
        unique case (state_d)
            ST_RSTH: begin
                avm_write_d     = 1'b1;
                avm_address_d   = LDR_ADDR_RESET;
                avm_writedata_d = DW'(1);
            end
            ST_RSTL: begin
                avm_write_d   = 1'b1;
                avm_address_d = LDR_ADDR_RESET;
            end
            ST_LOAD: begin
                avm_write_d   = 1'b1;
                avm_address_d = LDR_ADDR_R_BASE + 16'(idx_d);
                for (int i = 0; i < N; i++) begin
                    if (idx_d == IW'(i)) begin
                        avm_writedata_d = r_d[i*DW +: DW];
                    end
                end
            end
            ST_GO: begin
                avm_write_d     = 1'b1;
                avm_address_d   = LDR_ADDR_START;
                avm_writedata_d = DW'(1);
            end
            ST_POLL: begin
                avm_read_d    = 1'b1;
                avm_address_d = LDR_ADDR_DONE;
            end
            ST_STOP: begin
                avm_write_d   = 1'b1;
                avm_address_d = LDR_ADDR_START;
            end
            ST_RDA: begin
                if (idx_d < IW'(N)) begin
                    avm_read_d    = 1'b1;
                    avm_address_d = LDR_ADDR_A_BASE + 16'(idx_d);
                end
            end
            ST_ABORT: begin
                avm_write_d = 1'b1;
                if (idx_d == '0) begin
                    avm_address_d = LDR_ADDR_START;
                end else begin
                    avm_address_d   = LDR_ADDR_RESET;
                    avm_writedata_d = DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            r_q             <= '0;
            a_q             <= '0;
            timeout_q       <= 1'b0;
            in_ready_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            r_q             <= r_d;
            a_q             <= a_d;
            timeout_q       <= timeout_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign a_vec         = a_q;
    assign timeout       = timeout_q;
    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_ldr_avm_driver.sv
// Bench for ldr_avm_driver: a behavioural LDR slave answers the bus, and every run
// is checked against the transfer list, poll count, latency and A vector derived from R.
`timescale 1ns/1ps
module tb_ldr_avm_driver;

    localparam int ORDER    = 10;
    localparam int DW       = 16;
    localparam int N        = ORDER + 1;
    localparam int VW       = N * DW;
    localparam int POLL_GAP = 4;
    localparam int TIMEOUT  = 8;
    localparam int STEP     = 2 + POLL_GAP;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] r_vec = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] a_vec;
    logic          timeout;
    logic [15:0]   avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rw_clash = 0;
    int accept_edge = 0;
    int out_edge = 0;
    ev_t ev_q[$];
    ev_t exp_q[$];

    // Behavioural LDR slave state
    logic [VW-1:0] r_mem = '0;
    logic [VW-1:0] a_mem = '0;
    logic          running = 1'b0;
    logic          never_done = 1'b0;
    int            dcnt = 0;
    int            d_cycles = 20;
    logic          done_now;

    ldr_avm_driver #(
        .ORDER(ORDER), .DW(DW), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .r_vec(r_vec),
        .out_valid(out_valid), .out_ready(out_ready), .a_vec(a_vec),
        .timeout(timeout),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // Stand-in for the solver: A is a fixed signed mix of the loaded R words.
    function automatic logic [VW-1:0] lpc_model(input logic [VW-1:0] r);
        logic [VW-1:0] a;
        for (int i = 0; i < N; i++) begin
            a[i*DW +: DW] = (r[(ORDER-i)*DW +: DW] ^ 16'hC35A) - r[i*DW +: DW];
        end
        return a;
    endfunction

    assign done_now = running && !never_done && (dcnt >= d_cycles);

    always @(posedge clk) begin
        if (avm_read) begin
            if (avm_address == 16'd2) begin
                avm_readdata <= {15'($urandom), done_now};
            end else if (avm_address >= 16'd14 && avm_address < 16'(14 + N)) begin
                avm_readdata <= a_mem[(int'(avm_address) - 14)*DW +: DW];
            end else begin
                avm_readdata <= 16'hDEAD;
            end
        end
        if (running) dcnt <= dcnt + 1;
        if (avm_write) begin
            if (avm_address == 16'd0 && avm_writedata[0]) begin
                running <= 1'b0;
            end else if (avm_address == 16'd1 && avm_writedata[0]) begin
                running <= 1'b1;
                dcnt    <= 0;
                a_mem   <= lpc_model(r_mem);
            end else if (avm_address >= 16'd3 && avm_address < 16'(3 + N)) begin
                r_mem[(int'(avm_address) - 3)*DW +: DW] <= avm_writedata;
            end
        end
    end

    // Bus monitor: one entry per strobe cycle, in order.
    always @(posedge clk) begin
        ev_t e;
        if (avm_read && avm_write) rw_clash++;
        if (avm_write || avm_read) begin
            e.wr   = avm_write;
            e.addr = avm_address;
            e.data = avm_write ? avm_writedata : 16'h0;
            ev_q.push_back(e);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic wr, input int addr, input logic [15:0] data);
        ev_t e;
        e.wr   = wr;
        e.addr = 16'(addr);
        e.data = data;
        exp_q.push_back(e);
    endfunction

    function automatic void build_expect(input logic [VW-1:0] r, input int polls, input logic finished);
        exp_q.delete();
        push_exp(1'b1, 0, 16'd1);
        push_exp(1'b1, 0, 16'd0);
        for (int i = 0; i < N; i++) push_exp(1'b1, 3 + i, r[i*DW +: DW]);
        push_exp(1'b1, 1, 16'd1);
        for (int p = 0; p < polls; p++) push_exp(1'b0, 2, 16'd0);
        push_exp(1'b1, 1, 16'd0);
        if (finished) begin
            for (int i = 0; i < N; i++) push_exp(1'b0, 14 + i, 16'd0);
        end else begin
            push_exp(1'b1, 0, 16'd1);
        end
    endfunction

    task automatic compareEvents(input string tag);
        int n;
        n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        checkOutput({tag, " bus count"}, VW'(ev_q.size()), VW'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s bus[%0d]", tag, i), VW'(ev_q[i]), VW'(exp_q[i]));
        end
    endtask

    task automatic applyStimulus(input logic [VW-1:0] vec, input logic keep, input logic [VW-1:0] next_vec);
        logic ok;
        ok = 1'b0;
        r_vec    = vec;
        in_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept", VW'(ok), VW'(1));
        accept_edge = cyc;
        ev_q.delete();
        @(posedge clk);
        #1;
        if (keep) begin
            r_vec = next_vec;
        end else begin
            in_valid = 1'b0;
            r_vec    = ~vec;
        end
    endtask

    task automatic waitResult(input logic [VW-1:0] r, input int d, input string tag, input logic hold);
        logic found;
        int   polls;
        int   lat;
        int   bad;
        found = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, " out_valid"}, VW'(found), VW'(1));
        if (found) begin
            out_edge = cyc - 1;
            polls = (d + STEP - 1) / STEP + 1;
            lat   = 2 + N + 1 + 2*polls + (polls-1)*POLL_GAP + 1 + N + 1;
            checkOutput({tag, " latency"}, VW'(out_edge - accept_edge), VW'(lat));
            checkOutput({tag, " a_vec"}, a_vec, lpc_model(r));
            checkOutput({tag, " in_ready busy"}, VW'(in_ready), VW'(0));
            build_expect(r, polls, 1'b1);
            compareEvents(tag);
            if (hold) begin
                bad = 0;
                for (int n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (!(out_valid === 1'b1 && a_vec === lpc_model(r) && in_ready === 1'b0)) bad++;
                end
                checkOutput({tag, " hold stable"}, VW'(bad), VW'(0));
                out_ready = 1'b1;
            end
            @(negedge clk);
            checkOutput({tag, " out_valid drop"}, VW'(out_valid), VW'(0));
        end
    endtask

    initial begin
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        logic          seen;
        logic          ov_seen;
        int            d;

        // Reset: outputs zero while held, in_ready rises on the 2nd cycle after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst in_ready", VW'(in_ready), VW'(0));
        checkOutput("rst out_valid", VW'(out_valid), VW'(0));
        checkOutput("rst timeout", VW'(timeout), VW'(0));
        checkOutput("rst avm_read", VW'(avm_read), VW'(0));
        checkOutput("rst avm_write", VW'(avm_write), VW'(0));
        checkOutput("rst avm_address", VW'(avm_address), VW'(0));
        checkOutput("rst avm_writedata", VW'(avm_writedata), VW'(0));
        checkOutput("rst a_vec", a_vec, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst in_ready 1st", VW'(in_ready), VW'(0));
        @(negedge clk);
        checkOutput("post-rst in_ready 2nd", VW'(in_ready), VW'(1));

        // Nominal vector, D=20
        v1 = '0;
        v1[0*DW +: DW] = 16'h4000;
        v1[1*DW +: DW] = 16'h3000;
        v1[2*DW +: DW] = 16'h2000;
        d_cycles = 20;
        applyStimulus(v1, 1'b0, '0);
        waitResult(v1, 20, "nominal", 1'b0);

        // Backpressure on the output side
        for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
        d_cycles  = 9;
        out_ready = 1'b0;
        applyStimulus(v1, 1'b0, '0);
        waitResult(v1, 9, "backpressure", 1'b1);
        @(negedge clk);
        checkOutput("backpressure in_ready back", VW'(in_ready), VW'(1));

        // Timeout: done never rises
        for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
        never_done = 1'b1;
        applyStimulus(v1, 1'b0, '0);
        seen = 1'b0;
        ov_seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
            if (timeout) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("timeout flag", VW'(seen), VW'(1));
        build_expect(v1, TIMEOUT, 1'b0);
        compareEvents("timeout");
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        checkOutput("timeout no out_valid", VW'(ov_seen), VW'(0));
        checkOutput("timeout quiet bus", VW'(ev_q.size()), VW'(exp_q.size()));
        checkOutput("timeout sticky", VW'(timeout), VW'(1));
        never_done = 1'b0;

        // Next accepted input clears timeout
        for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
        d_cycles = 0;
        applyStimulus(v1, 1'b0, '0);
        @(negedge clk);
        checkOutput("timeout cleared", VW'(timeout), VW'(0));
        waitResult(v1, 0, "after-timeout", 1'b0);

        // Mid-run reset during LOAD at i=5
        for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
        d_cycles = 14;
        applyStimulus(v1, 1'b0, '0);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (avm_write && avm_address == 16'd8) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("midrst reach load5", VW'(seen), VW'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst avm_write", VW'(avm_write), VW'(0));
        checkOutput("midrst avm_read", VW'(avm_read), VW'(0));
        checkOutput("midrst in_ready", VW'(in_ready), VW'(0));
        rst = 1'b0;
        for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
        applyStimulus(v1, 1'b0, '0);
        waitResult(v1, 14, "after-midrst", 1'b0);

        // Random runs, including the last poll that can still see done
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) v1[i*DW +: DW] = 16'($urandom);
            d = (k == 0) ? (TIMEOUT - 1) * STEP : int'($urandom_range(1, (TIMEOUT - 1) * STEP));
            d_cycles = d;
            applyStimulus(v1, 1'b0, '0);
            waitResult(v1, d, $sformatf("random%0d d=%0d", k, d), 1'b0);
        end

        // Back-to-back with in_valid held high
        for (int i = 0; i < N; i++) begin
            v1[i*DW +: DW] = 16'($urandom);
            v2[i*DW +: DW] = 16'($urandom);
        end
        d_cycles = 7;
        applyStimulus(v1, 1'b1, v2);
        waitResult(v1, 7, "b2b first", 1'b0);
        applyStimulus(v2, 1'b0, '0);
        checkOutput("b2b second after handshake", VW'(accept_edge >= out_edge + 3), VW'(1));
        waitResult(v2, 7, "b2b second", 1'b0);

        checkOutput("read/write exclusive", VW'(rw_clash), VW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
